// File: rtl/cb_pkg.sv
// Shared constants and pointer helpers for the multi-lane circular buffer.
// Optional same-cycle slot reuse in cb_multi is enabled by CB_SAME_CYCLE_FREE_EN.
package cb_pkg;

    localparam int CB_IDX_DEF   = 3;
    localparam int CB_WIDTH_DEF = 8;
    localparam int CB_CNT_W_DEF = CB_IDX_DEF + 1;

    // Occupancy needs one bit more than a pointer so that "full" is representable.
    function automatic int unsigned cnt_width(input int unsigned idx);
        return idx + 1;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned ptr,
                                             input int unsigned n,
                                             input int unsigned idx);
        return (ptr + n) & ((32'd1 << idx) - 32'd1);
    endfunction

endpackage

// File: rtl/cb_lane_grant.sv
// Grants the contiguous-from-lane-0 run of requests, capped by a limit.
// A lane after the first idle request is never granted in that cycle.
module cb_lane_grant #(
    parameter int N  = 2,
    parameter int LW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] limit,
    output logic [LW-1:0] grant
);

    logic [LW-1:0] pfx;
    logic          run;

    always_comb begin
        pfx = '0;
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && req[i]) begin
                pfx = pfx + LW'(1);
            end else begin
                run = 1'b0;
            end
        end
        grant = (pfx < limit) ? pfx : limit;
    end

endmodule

// File: rtl/cb_multi.sv
// Parametrised multi-lane circular buffer with generalised tail rollback.
// Define CB_SAME_CYCLE_FREE_EN to let inserts reuse slots vacated by same-cycle removes.
module cb_multi
    import cb_pkg::*;
#(
    parameter int CB_IDX   = CB_IDX_DEF,
    parameter int CB_WIDTH = CB_WIDTH_DEF,
    parameter int N_IN     = 2,
    parameter int N_OUT    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN-1:0]           din_en,
    input  logic [N_IN*CB_WIDTH-1:0]  din,
    input  logic [N_OUT-1:0]          dout_req,
    input  logic                      move_tail,
    input  logic [CB_IDX:0]           tail_offset,
    output logic [N_OUT*CB_WIDTH-1:0] dout,
    output logic [N_OUT-1:0]          dout_valid,
    output logic [CB_IDX:0]           count,
    output logic                      full,
    output logic                      full_almost,
    output logic                      empty,
    output logic                      empty_almost
);

    localparam int            CB_DEPTH = 1 << CB_IDX;
    localparam int            CW       = cnt_width(CB_IDX);
    localparam logic [CW-1:0] DEPTH_C  = CW'(CB_DEPTH);

    logic [CB_WIDTH-1:0] mem [CB_DEPTH];
    logic [CB_IDX-1:0]   head;
    logic [CB_IDX-1:0]   tail;
    logic [CW-1:0]       cnt;

    logic [CB_IDX-1:0]   head_nxt;
    logic [CB_IDX-1:0]   tail_nxt;
    logic [CW-1:0]       cnt_nxt;

    logic [CW-1:0]       off_clamp;
    logic [CW-1:0]       rm_limit;
    logic [CW-1:0]       free_slots;
    logic [CW-1:0]       free_now;
    logic [CW-1:0]       n_rm;
    logic [CW-1:0]       n_in;
    logic [N_IN-1:0]     ins_req;

    // Rollback can only shrink occupancy, and it shadows every insert request.
    always_comb begin
        off_clamp = (tail_offset > cnt) ? cnt : tail_offset;
        rm_limit  = move_tail ? off_clamp : cnt;
        ins_req   = move_tail ? '0 : din_en;
    end

    always_comb begin
`ifdef CB_SAME_CYCLE_FREE_EN
        free_slots = DEPTH_C - cnt + n_rm;
`else
        free_slots = DEPTH_C - cnt;
`endif
    end

    cb_lane_grant #(
        .N  (N_OUT),
        .LW (CW)
    ) u_rm_grant (
        .req   (dout_req),
        .limit (rm_limit),
        .grant (n_rm)
    );

    cb_lane_grant #(
        .N  (N_IN),
        .LW (CW)
    ) u_in_grant (
        .req   (ins_req),
        .limit (free_slots),
        .grant (n_in)
    );

    always_comb begin
        head_nxt = CB_IDX'(wrap_add(32'(head), 32'(n_rm), CB_IDX));
        if (move_tail) begin
            tail_nxt = CB_IDX'(wrap_add(32'(head), 32'(off_clamp), CB_IDX));
            cnt_nxt  = off_clamp - n_rm;
        end else begin
            tail_nxt = CB_IDX'(wrap_add(32'(tail), 32'(n_in), CB_IDX));
            cnt_nxt  = cnt + n_in - n_rm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < CB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
            for (int i = 0; i < N_IN; i++) begin
                if (CW'(i) < n_in) begin
                    mem[CB_IDX'(wrap_add(32'(tail), i, CB_IDX))] <= din[i*CB_WIDTH +: CB_WIDTH];
                end
            end
        end
    end

    // Handshake: lane i holds live data when dout_valid[i]=1; a dout_req on lane i
    // consumes that entry at the next edge only if it lies in the granted prefix.
    always_comb begin
        dout       = '0;
        dout_valid = '0;
        for (int i = 0; i < N_OUT; i++) begin
            dout[i*CB_WIDTH +: CB_WIDTH] = mem[CB_IDX'(wrap_add(32'(head), i, CB_IDX))];
            dout_valid[i]                = CW'(i) < cnt;
        end
    end

    always_comb begin
        free_now     = DEPTH_C - cnt;
        count        = cnt;
        full         = (cnt == DEPTH_C);
        empty        = (cnt == '0);
        full_almost  = (free_now != '0) && (free_now < CW'(N_IN));
        empty_almost = (cnt != '0) && (cnt < CW'(N_OUT));
    end

endmodule

// File: tb/tb_cb_multi.sv
// Directed scoreboard bench for cb_multi at depth 8, width 8, two lanes each way.
// Expected snapshots are queued per cycle and checked at the falling edge.
module tb_cb_multi;

    logic        clk;
    logic        reset;
    logic [1:0]  din_en;
    logic [15:0] din;
    logic [1:0]  dout_req;
    logic        move_tail;
    logic [3:0]  tail_offset;
    logic [15:0] dout;
    logic [1:0]  dout_valid;
    logic [3:0]  count;
    logic        full;
    logic        full_almost;
    logic        empty;
    logic        empty_almost;

    cb_multi #(
        .CB_IDX   (3),
        .CB_WIDTH (8),
        .N_IN     (2),
        .N_OUT    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din_en       (din_en),
        .din          (din),
        .dout_req     (dout_req),
        .move_tail    (move_tail),
        .tail_offset  (tail_offset),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .count        (count),
        .full         (full),
        .full_almost  (full_almost),
        .empty        (empty),
        .empty_almost (empty_almost)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [25:0] exp_q[$];
    logic [25:0] msk_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;

    logic [25:0] act;
    assign act = {count, full, full_almost, empty, empty_almost, dout_valid, dout};

    // Snapshot for occupancy c at depth 8 with two output lanes; d0/d1 are head, head+1.
    function automatic logic [1:0] exp_dv(input int c);
        return (c >= 2) ? 2'b11 : ((c == 1) ? 2'b01 : 2'b00);
    endfunction

    function automatic logic [25:0] mk(input int c, input logic [7:0] d0, input logic [7:0] d1);
        return {4'(c), c == 8, c == 7, c == 0, c == 1, exp_dv(c), d1, d0};
    endfunction

    function automatic logic [25:0] mkm(input int c);
        logic [1:0] dv;
        dv = exp_dv(c);
        return {10'h3ff, dv[1] ? 8'hff : 8'h00, dv[0] ? 8'hff : 8'h00};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [25:0] e;
            logic [25:0] m;
            string       nm;
            e  = exp_q.pop_front();
            m  = msk_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ((act & m) !== (e & m)) begin
                failures++;
                $display("FAIL %s expected=%h actual=%h", nm, e & m, act & m);
            end
        end
    end

    // driver: state expected in this cycle, then inputs applied for the next edge
    task automatic step(input int c, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] en, input logic [15:0] di, input logic [1:0] rq,
                        input logic mt = 1'b0, input logic [3:0] off = 4'd0);
        @(posedge clk);
        #1;
        din_en      = en;
        din         = di;
        dout_req    = rq;
        move_tail   = mt;
        tail_offset = off;
        exp_q.push_back(mk(c, d0, d1));
        msk_q.push_back(mkm(c));
        name_q.push_back($sformatf("step%0d", step_no));
        step_no++;
    endtask

    task automatic expect_reset(input string nm);
        exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000});
        msk_q.push_back(26'h3ff_ffff);
        name_q.push_back(nm);
    endtask

    initial begin
        reset       = 1'b0;
        din_en      = '0;
        din         = '0;
        dout_req    = '0;
        move_tail   = 1'b0;
        tail_offset = '0;
        @(posedge clk);
        #1;
        expect_reset("reset_init");
        @(negedge clk);
        #2;
        reset = 1'b1;

        // fill with pairs, fifth pair dropped when full
        step(0, 8'h00, 8'h00, 2'b11, 16'h0201, 2'b00);
        step(2, 8'h01, 8'h02, 2'b11, 16'h0403, 2'b00);
        step(4, 8'h01, 8'h02, 2'b11, 16'h0605, 2'b00);
        step(6, 8'h01, 8'h02, 2'b11, 16'h0807, 2'b00);
        step(8, 8'h01, 8'h02, 2'b11, 16'h0a09, 2'b00);
        // drain in pairs, extra request on empty does nothing
        step(8, 8'h01, 8'h02, 2'b00, 16'h0000, 2'b11);
        step(6, 8'h03, 8'h04, 2'b00, 16'h0000, 2'b11);
        step(4, 8'h05, 8'h06, 2'b00, 16'h0000, 2'b11);
        step(2, 8'h07, 8'h08, 2'b00, 16'h0000, 2'b11);
        step(0, 8'h00, 8'h00, 2'b00, 16'h0000, 2'b11);

        // advance head to 5
        step(0, 8'h00, 8'h00, 2'b11, 16'h1211, 2'b00);
        step(2, 8'h11, 8'h12, 2'b11, 16'h1413, 2'b00);
        step(4, 8'h11, 8'h12, 2'b01, 16'h0015, 2'b00);
        step(5, 8'h11, 8'h12, 2'b00, 16'h0000, 2'b11);
        step(3, 8'h13, 8'h14, 2'b00, 16'h0000, 2'b11);
        step(1, 8'h15, 8'h00, 2'b00, 16'h0000, 2'b01);

        // single-lane inserts wrapping from slot 5, ninth dropped
        step(0, 8'h00, 8'h00, 2'b01, 16'h0020, 2'b00);
        step(1, 8'h20, 8'h00, 2'b01, 16'h0021, 2'b00);
        step(2, 8'h20, 8'h21, 2'b01, 16'h0022, 2'b00);
        step(3, 8'h20, 8'h21, 2'b01, 16'h0023, 2'b00);
        step(4, 8'h20, 8'h21, 2'b01, 16'h0024, 2'b00);
        step(5, 8'h20, 8'h21, 2'b01, 16'h0025, 2'b00);
        step(6, 8'h20, 8'h21, 2'b01, 16'h0026, 2'b00);
        step(7, 8'h20, 8'h21, 2'b01, 16'h0027, 2'b00);
        step(8, 8'h20, 8'h21, 2'b01, 16'h0028, 2'b00);
        step(8, 8'h20, 8'h21, 2'b00, 16'h0000, 2'b11);
        step(6, 8'h22, 8'h23, 2'b00, 16'h0000, 2'b11);
        step(4, 8'h24, 8'h25, 2'b00, 16'h0000, 2'b11);
        step(2, 8'h26, 8'h27, 2'b00, 16'h0000, 2'b11);
        // insert with a gap at lane 0 grants nothing
        step(0, 8'h00, 8'h00, 2'b10, 16'h9998, 2'b00);

        // streaming: two in, two out per cycle
        step(0, 8'h00, 8'h00, 2'b11, 16'h0201, 2'b00);
        step(2, 8'h01, 8'h02, 2'b11, 16'h0403, 2'b11);
        step(2, 8'h03, 8'h04, 2'b11, 16'h0605, 2'b11);
        step(2, 8'h05, 8'h06, 2'b11, 16'h0807, 2'b11);
        step(2, 8'h07, 8'h08, 2'b11, 16'h0a09, 2'b11);
        step(2, 8'h09, 8'h0a, 2'b00, 16'h0000, 2'b01);
        step(1, 8'h0a, 8'h00, 2'b00, 16'h0000, 2'b10);
        step(1, 8'h0a, 8'h00, 2'b00, 16'h0000, 2'b01);

        // set up head=3, count=6, then roll back to offset 2 with one remove
        step(0, 8'h00, 8'h00, 2'b11, 16'h4140, 2'b00);
        step(2, 8'h40, 8'h41, 2'b11, 16'h4342, 2'b00);
        step(4, 8'h40, 8'h41, 2'b00, 16'h0000, 2'b11);
        step(2, 8'h42, 8'h43, 2'b00, 16'h0000, 2'b11);
        step(0, 8'h00, 8'h00, 2'b11, 16'h5150, 2'b00);
        step(2, 8'h50, 8'h51, 2'b11, 16'h5352, 2'b00);
        step(4, 8'h50, 8'h51, 2'b11, 16'h5554, 2'b00);
        step(6, 8'h50, 8'h51, 2'b11, 16'heeef, 2'b01, 1'b1, 4'd2);
        // offset beyond count is clamped: no change
        step(1, 8'h51, 8'h00, 2'b00, 16'h0000, 2'b00, 1'b1, 4'd5);
        step(1, 8'h51, 8'h00, 2'b00, 16'h0000, 2'b11);

        // async reset between edges at count 5
        step(0, 8'h00, 8'h00, 2'b11, 16'h6261, 2'b00);
        step(2, 8'h61, 8'h62, 2'b11, 16'h6463, 2'b00);
        step(4, 8'h61, 8'h62, 2'b01, 16'h0065, 2'b00);
        step(5, 8'h61, 8'h62, 2'b00, 16'h0000, 2'b00);
        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_reset("reset_async");
        @(negedge clk);
        #2;
        reset = 1'b1;

        // full buffer with two removes and two inserts in one cycle
        step(0, 8'h00, 8'h00, 2'b11, 16'h7271, 2'b00);
        step(2, 8'h71, 8'h72, 2'b11, 16'h7473, 2'b00);
        step(4, 8'h71, 8'h72, 2'b11, 16'h7675, 2'b00);
        step(6, 8'h71, 8'h72, 2'b11, 16'h7877, 2'b00);
        step(8, 8'h71, 8'h72, 2'b11, 16'h7a79, 2'b11);
`ifdef CB_SAME_CYCLE_FREE_EN
        step(8, 8'h73, 8'h74, 2'b00, 16'h0000, 2'b11);
        step(6, 8'h75, 8'h76, 2'b00, 16'h0000, 2'b11);
        step(4, 8'h77, 8'h78, 2'b00, 16'h0000, 2'b11);
        step(2, 8'h79, 8'h7a, 2'b00, 16'h0000, 2'b11);
        step(0, 8'h00, 8'h00, 2'b00, 16'h0000, 2'b00);
`else
        step(6, 8'h73, 8'h74, 2'b00, 16'h0000, 2'b11);
        step(4, 8'h75, 8'h76, 2'b00, 16'h0000, 2'b11);
        step(2, 8'h77, 8'h78, 2'b00, 16'h0000, 2'b11);
        step(0, 8'h00, 8'h00, 2'b00, 16'h0000, 2'b00);
`endif

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cb_multi.md
Name: cb_multi

Overview:
- Parametrised successor to the 2-in/2-out circular buffer.
- Depth (2^CB_IDX), data width, and insert/remove lane counts are all configurable.
- Tail-rollback (squash) is generalised to any offset from head and may coexist with same-cycle removes.
- Sits between dispatch and in-order retire structures, e.g. ROB or free-list style queues.

Parameters:
- CB_IDX, 3, log2 of depth; CB_DEPTH = 2^CB_IDX (localparam).
- CB_WIDTH, 8, bits per entry.
- N_IN, 2, insert lanes (1..CB_DEPTH).
- N_OUT, 2, remove lanes (1..CB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- din_en  in  N_IN  per-lane insert request.
- din  in  N_IN*CB_WIDTH  insert data; lane i at bits [i*CB_WIDTH +: CB_WIDTH].
- dout_req  in  N_OUT  per-lane remove request.
- move_tail  in  1  tail rollback strobe.
- tail_offset  in  CB_IDX+1  new occupancy measured from the current head.
- dout  out  N_OUT*CB_WIDTH  entry at head+i on lane i (combinational).
- dout_valid  out  N_OUT  lane i valid when i < count.
- count  out  CB_IDX+1  occupancy, 0..CB_DEPTH.
- full  out  1  count == CB_DEPTH.
- full_almost  out  1  0 < free < N_IN.
- empty  out  1  count == 0.
- empty_almost  out  1  0 < count < N_OUT.

Behaviour:
- Reset (async, reset==0):
  - head=tail=count=0; all data entries cleared to 0.
  - dout=0, dout_valid=0, empty=1, full=0, full_almost=0, empty_almost=0.
  - Takes effect immediately, mid-operation included. The first update occurs on the first rising edge after release.
- Lane grant is prefix-only:
  - Lanes are granted from lane 0 up to the first deasserted request.
  - Lanes after a gap are ignored that cycle (din_en=2'b10 inserts nothing).
- Remove:
  - n_rm = min(granted dout_req prefix, count at start of cycle).
  - At the edge, head += n_rm (mod CB_DEPTH).
  - Data at head..head+n_rm-1 is presented on dout in the same cycle as the request (zero latency).
- Insert:
  - free = CB_DEPTH - count at start of cycle.
  - n_in = min(granted din_en prefix, free). Lane i writes data[tail+i] for i < n_in.
  - At the edge, tail += n_in (mod CB_DEPTH).
  - Excess requests are dropped silently; count saturates at CB_DEPTH.
  - Slots freed in the same cycle are not usable unless CB_SAME_CYCLE_FREE_EN is defined.
- count_next = count + n_in - n_rm. Full-depth wrap-around on head and tail is via CB_IDX-bit pointer truncation.
- move_tail=1 takes priority over inserts:
  - All din_en are ignored.
  - tail_offset is clamped to count.
  - Removes are granted only among the first tail_offset entries: n_rm = min(prefix, tail_offset).
  - tail_next = head + tail_offset; head_next = head + n_rm; count_next = tail_offset - n_rm.
  - Entry contents are untouched.
- move_tail with tail_offset == count is a no-op apart from removes.

Optional Feature:
- Macro CB_SAME_CYCLE_FREE_EN.
- Defined: free = CB_DEPTH - count + n_rm. Inserts may fill slots vacated by same-cycle removes, so a full buffer with 2 removes plus 2 inserts stays full.
- Not defined: free uses pre-cycle count only. In the same case, 2 removes are taken, 0 inserts, and count becomes CB_DEPTH-2.
- Not applicable under move_tail, since inserts are ignored.

Decomposition:
- Package cb_pkg:
  - CB_IDX and CB_WIDTH defaults.
  - Count-width helper constant.
  - Function wrap_add(ptr, n) for mod-depth pointer arithmetic.
- Sub-module cb_lane_grant:
  - Parameterised by lane count.
  - Inputs: request vector, limit.
  - Output: granted count = min(length of contiguous-from-lane-0 prefix, limit).
  - Instantiated twice, once for insert and once for remove.

Test Plan (CB_IDX=3, CB_WIDTH=8, N_IN=N_OUT=2 unless noted):
- Reset, then din_en=2'b11, din={0,3} for 5 cycles:
  - count reaches 2,4,6,8.
  - full=1 after the 4th edge; full_almost=0 throughout (free steps 8,6,4,2 never < N_IN).
  - 5th insert dropped: count stays 8, data unchanged.
- From full, dout_req=2'b11 for 5 cycles:
  - dout lanes show entries in FIFO order; count 6,4,2,0.
  - empty=1 and head wraps to 0.
  - 5th cycle: dout_valid=0, count stays 0.
- Reset, head advanced to 5. Insert 1/cycle, data 5, for 9 cycles:
  - Entries wrap through 5,6,7,0..4.
  - full_almost=1 at count 7; full at count 8; 9th insert dropped.
- Insert {2,1}, then {4,3},{6,5},{8,7},{10,9} each with dout_req=2'b11:
  - count stays 2.
  - dout pairs read (1,2),(3,4),(5,6),(7,8).
  - Then dout_req=2'b01 drains 9, then 10.
- count=6, head=3: move_tail=1, tail_offset=2, dout_req=2'b01, din_en=2'b11:
  - Next state: head=4, tail=5, count=1.
  - No insert written; dout lane0 showed entry 3 before the edge.
- Async reset at count=5 between edges:
  - count=0, empty=1, dout_valid=0 immediately.
- With CB_SAME_CYCLE_FREE_EN, full buffer with 2 removes plus 2 inserts stays full.
